// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the pipeline stages.
//   - MIPS32 instruction field positions (MSB of each field, plus the
//     widths of the immediate and jump-target fields).
//   - occ_t: occupancy of a two-entry skid-buffered pipeline register.
package cpu_pkg;

  localparam int OPC_MSB   = 31;
  localparam int RS_MSB    = 25;
  localparam int RT_MSB    = 20;
  localparam int RD_MSB    = 15;
  localparam int SHAMT_MSB = 10;
  localparam int FUNCT_MSB = 5;
  localparam int IMM_W     = 16;
  localparam int TARGET_W  = 26;

  localparam int OPC_W   = 6;
  localparam int REG_W   = 5;
  localparam int FUNCT_W = 6;

  // EMPTY: nothing held, ONE: head valid, FULL: head and skid valid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

endpackage

// File: rtl/instr_fields.sv
// instr_fields: purely combinational split of a 32-bit MIPS32 word into
// its fields. Shared by the decode-side stages.
// Ports:
//   instr   in  32  raw instruction word
//   opcode  out 6   instr[31:26]
//   rs      out 5   instr[25:21]
//   rt      out 5   instr[20:16]
//   rd      out 5   instr[15:11]
//   shamt   out 5   instr[10:6]
//   funct   out 6   instr[5:0]
//   imm16   out 16  instr[15:0]
//   target  out 26  instr[25:0]
module instr_fields
  import cpu_pkg::*;
(
  input  logic [31:0]         instr,
  output logic [OPC_W-1:0]    opcode,
  output logic [REG_W-1:0]    rs,
  output logic [REG_W-1:0]    rt,
  output logic [REG_W-1:0]    rd,
  output logic [REG_W-1:0]    shamt,
  output logic [FUNCT_W-1:0]  funct,
  output logic [IMM_W-1:0]    imm16,
  output logic [TARGET_W-1:0] target
);

  assign opcode = instr[OPC_MSB   -: OPC_W];
  assign rs     = instr[RS_MSB    -: REG_W];
  assign rt     = instr[RT_MSB    -: REG_W];
  assign rd     = instr[RD_MSB    -: REG_W];
  assign shamt  = instr[SHAMT_MSB -: REG_W];
  assign funct  = instr[FUNCT_MSB -: FUNCT_W];
  assign imm16  = instr[IMM_W-1:0];
  assign target = instr[TARGET_W-1:0];

endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID pipeline register with a 2-entry skid buffer.
// Holds {pc_plus4, instr} from fetch, presents the head entry to decode
// and splits the head instruction into its MIPS32 fields.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   flush                drop every held entry (branch/jump redirect)
//   in_valid/in_ready    fetch handshake; in_ready comes from a flop
//   in_pc_plus4,in_instr fetched entry
//   out_valid/out_ready  decode handshake
//   out_pc_plus4,out_instr, out_opcode..out_target  head entry and fields
// Optional feature (macro IF_ID_STALL_CNT_EN):
//   stall_cnt  out 32  count of cycles where fetch offered but the stage
//                      was full; cleared only by rst, wraps at 2^32.
module if_id_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_pc_plus4,
  input  logic [DATA_W-1:0]   in_instr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_pc_plus4,
  output logic [DATA_W-1:0]   out_instr,
  output logic [OPC_W-1:0]    out_opcode,
  output logic [REG_W-1:0]    out_rs,
  output logic [REG_W-1:0]    out_rt,
  output logic [REG_W-1:0]    out_rd,
  output logic [REG_W-1:0]    out_shamt,
  output logic [FUNCT_W-1:0]  out_funct,
  output logic [IMM_W-1:0]    out_imm16,
`ifdef IF_ID_STALL_CNT_EN
  output logic [TARGET_W-1:0] out_target,
  output logic [31:0]         stall_cnt
`else
  output logic [TARGET_W-1:0] out_target
`endif
);

  // The occupancy FSM only understands a head and a single skid entry.
  if (DEPTH != 2) begin : g_depth_check
    $error("if_id_stage: DEPTH must be 2");
  end

  occ_t              state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [DATA_W-1:0] head_pc_q, head_pc_d;
  logic [DATA_W-1:0] head_instr_q, head_instr_d;
  logic [DATA_W-1:0] skid_pc_q, skid_pc_d;
  logic [DATA_W-1:0] skid_instr_q, skid_instr_d;
  logic              accept;
  logic              pop;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = in_ready_q;
  assign accept    = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;

  // Next occupancy and data movement. Flush wins over accept/pop and
  // leaves the data registers untouched; only the state is cleared.
  always_comb begin
    state_d      = state_q;
    head_pc_d    = head_pc_q;
    head_instr_d = head_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;

    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            head_pc_d    = in_pc_plus4;
            head_instr_d = in_instr;
            state_d      = ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            head_pc_d    = in_pc_plus4;
            head_instr_d = in_instr;
          end else if (accept) begin
            skid_pc_d    = in_pc_plus4;
            skid_instr_d = in_instr;
            state_d      = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only a pop can move things.
          if (pop) begin
            head_pc_d    = skid_pc_q;
            head_instr_d = skid_instr_q;
            state_d      = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end

    // Registered ready reflects the state that will hold after the edge.
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      in_ready_q   <= 1'b1;
      head_pc_q    <= '0;
      head_instr_q <= '0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      head_pc_q    <= head_pc_d;
      head_instr_q <= head_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  assign out_pc_plus4 = head_pc_q;
  assign out_instr    = head_instr_q;

  instr_fields u_fields (
    .instr  (head_instr_q),
    .opcode (out_opcode),
    .rs     (out_rs),
    .rt     (out_rt),
    .rd     (out_rd),
    .shamt  (out_shamt),
    .funct  (out_funct),
    .imm16  (out_imm16),
    .target (out_target)
  );

`ifdef IF_ID_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Counts fetch stalls; deliberately survives flush. Wraps naturally.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (in_valid && !in_ready_q) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Pipeline stage between instruction fetch and decode/execute.
- Registers each fetched {pc_plus4, instr} and splits instr into MIPS32 fields; imm16 goes to the 16→32 sign-extend unit, the other fields go to the register file and control.
- Valid/ready on both sides, with a 2-entry skid buffer so that in_ready is registered.
- Synchronous flush for branch/jump redirects.

Parameters:
- DATA_W, 32, width of the instruction and of the PC.
- DEPTH, 2, skid entries; fixed at 2, and any other value is an elaboration error.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all held entries (redirect).
- in_valid  in  1  fetch offers an entry.
- in_ready  out  1  stage can accept; driven from a register.
- in_pc_plus4  in  DATA_W  PC+4 of the fetched instruction.
- in_instr  in  DATA_W  raw instruction word.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  decode consumes the head.
- out_pc_plus4  out  DATA_W  head PC+4.
- out_instr  out  DATA_W  head raw instruction.
- out_opcode  out  6  instr[31:26].
- out_rs  out  5  instr[25:21].
- out_rt  out  5  instr[20:16].
- out_rd  out  5  instr[15:11].
- out_shamt  out  5  instr[10:6].
- out_funct  out  6  instr[5:0].
- out_imm16  out  16  instr[15:0], feeds the sign-extend unit.
- out_target  out  26  instr[25:0].

Behaviour:
- Clocking: one clock. Reset is synchronous and active-high. Ports are named clk and rst.
- Storage:
  - head register H (drives the outputs) and skid register S.
  - Occupancy state: EMPTY (0 entries), ONE (H valid), FULL (H and S valid).
- Handshakes:
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready.
- Output decode: all field outputs are pure slices of H.instr, with no extra latency. When out_valid=0 the fields hold the last value and are don't-care.
- in_ready is registered: in_ready = (state != FULL), using state as it stands after the edge.
- out_valid = (state != EMPTY).
- Transitions, evaluated when flush=0:
  - EMPTY: accept → ONE, H←input. Otherwise stay.
  - ONE, accept & pop: H←input, stay ONE.
  - ONE, accept & !pop: S←input → FULL.
  - ONE, !accept & pop: → EMPTY.
  - FULL, pop: H←S → ONE. in_ready=0, so no accept is possible.
  - FULL, !pop: stay FULL and hold.
- Latency: an entry accepted at edge N is visible on the outputs after edge N (out_valid=1 in cycle N+1). There is no combinational path from in_* to out_*.
- Ordering: strict FIFO. An entry is never dropped or duplicated except by flush or rst.
- Flush:
  - Flush has priority over accept and pop in the same cycle: the input is dropped and the state goes to EMPTY.
  - After the flush edge: in_ready=1, out_valid=0.
  - H and S data are not cleared.
- Reset:
  - rst has priority over flush.
  - After the reset edge: state EMPTY, out_valid=0, in_ready=1, H/S data=0, so every field output is 0.
  - Reset in the middle of a transfer discards both entries.
- Backpressure boundary: with out_ready=0 the stage accepts exactly 2 entries, then in_ready=0. When out_ready rises, throughput returns to 1 per cycle after a one-cycle transition FULL→ONE.

Optional Feature:
- Macro: IF_ID_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt (32 bits).
  - Increments on every cycle with in_valid & !in_ready, and wraps at 2^32−1 → 0.
  - Cleared by rst only, not by flush.
- Not defined: port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package cpu_pkg holds:
  - field-position constants: OPC_MSB=31, RS_MSB=25, RT_MSB=20, RD_MSB=15, SHAMT_MSB=10, FUNCT_MSB=5, IMM_W=16, TARGET_W=26.
  - enum occ_t {EMPTY, ONE, FULL}.
- One sub-module is natural: instr_fields, purely combinational slicing of a 32-bit word into the fields. It is reused by later stages.

Test Plan:
- Reset, then stream: rst 1 cycle; in_valid=1, out_ready=1, instr 0x2128FFFC (addi $t0,$t1,-4), 0x012A4020, 0x08000010 → outputs one cycle later in order.
  - First entry: opcode=0x08, rs=9, rt=8, imm16=0xFFFC.
  - Third entry: target=0x0000010.
  - out_valid stays continuously 1.
- Backpressure: out_ready=0, offer 3 entries A/B/C → A, B accepted, in_ready=0 after the second edge, C held upstream. Raise out_ready → pops A, B, C in order with no loss.
- Simultaneous accept/pop in ONE: hold state ONE with in_valid & out_ready every cycle for 10 cycles → 10 entries out, state never FULL.
- Flush with an input offered: state FULL, assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1, and the offered entry is not later seen.
- Reset mid-operation: state FULL, rst=1 with flush=1 and in_valid=1 → outputs all 0, out_valid=0, in_ready=1. Under IF_ID_STALL_CNT_EN, stall_cnt=0.
- Stall counter (macro defined): 5 cycles of in_valid with in_ready=0 → stall_cnt=5. A following flush leaves it at 5.
